// File: rtl/demux_stream.sv
// Registered 1:NCH stream demultiplexer: per-channel one-entry output register,
// unicast/broadcast routing, sticky out-of-range select flag and saturating drop counter.
module demux_stream #(
    parameter int WIDTH     = 8,
    parameter int NCH       = 4,
    parameter int SELW      = $clog2(NCH),
    parameter int ZERO_IDLE = 1,
    parameter int CNTW      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SELW-1:0]        in_sel,
    input  logic                   in_bcast,
    output logic [NCH-1:0]         out_valid,
    input  logic [NCH-1:0]         out_ready,
    output logic [NCH*WIDTH-1:0]   out_data,
    output logic [CNTW-1:0]        drop_cnt,
    output logic                   sel_err
);

    localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

    logic [NCH-1:0]   valid_q, valid_d;
    logic [NCH-1:0]   free;
    logic [NCH-1:0]   load;
    logic [WIDTH-1:0] data_q [NCH];
    logic [WIDTH-1:0] data_d [NCH];
    logic [CNTW-1:0]  drop_q, drop_d;
    logic             err_q, err_d;
    logic             sel_oob;
    logic             accept;

    // A channel can take a new word if empty or being drained this cycle.
    assign free    = ~valid_q | out_ready;
    assign sel_oob = ({1'b0, in_sel} >= NCH_W);

    always_comb begin
        in_ready = 1'b0;
        if (in_bcast)
            in_ready = &free;
        else if (sel_oob)
            in_ready = 1'b1;
        else
            in_ready = free[in_sel];
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        valid_d = valid_q;
        load    = '0;
        for (int k = 0; k < NCH; k++) begin
            data_d[k] = data_q[k];
            load[k]   = accept & (in_bcast | (!sel_oob && in_sel == SELW'(k)));
            if (load[k]) begin
                valid_d[k] = 1'b1;
                data_d[k]  = in_data;
            end else if (valid_q[k] && out_ready[k]) begin
                valid_d[k] = 1'b0;
                if (ZERO_IDLE != 0)
                    data_d[k] = '0;
            end
        end
    end

    // Out-of-range unicast words are swallowed and accounted for here.
    always_comb begin
        drop_d = drop_q;
        err_d  = err_q;
        if (accept && !in_bcast && sel_oob) begin
            err_d = 1'b1;
            if (drop_q != '1)
                drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            drop_q  <= '0;
            err_q   <= 1'b0;
            for (int k = 0; k < NCH; k++)
                data_q[k] <= '0;
        end else begin
            valid_q <= valid_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
            for (int k = 0; k < NCH; k++)
                data_q[k] <= data_d[k];
        end
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < NCH; k++)
            out_data[k*WIDTH +: WIDTH] = data_q[k];
    end

    assign out_valid = valid_q;
    assign drop_cnt  = drop_q;
    assign sel_err   = err_q;

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: a 4-channel zero-idle instance and a 3-channel hold-idle
// instance, each checked every cycle against a per-channel occupancy model.
module tb_demux_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       iv   [2];
    logic       ibc  [2];
    logic [1:0] isel [2];
    logic [7:0] idat [2];
    logic [3:0] ordy [2];

    logic        irdy0, irdy1;
    logic [3:0]  ov0;
    logic [2:0]  ov1;
    logic [31:0] od0;
    logic [23:0] od1;
    logic [7:0]  dc0, dc1;
    logic        se0, se1;

    demux_stream #(.WIDTH(8), .NCH(4), .ZERO_IDLE(1), .CNTW(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy0), .in_data(idat[0]),
        .in_sel(isel[0]), .in_bcast(ibc[0]), .out_valid(ov0), .out_ready(ordy[0]),
        .out_data(od0), .drop_cnt(dc0), .sel_err(se0));

    demux_stream #(.WIDTH(8), .NCH(3), .SELW(2), .ZERO_IDLE(0), .CNTW(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy1), .in_data(idat[1]),
        .in_sel(isel[1]), .in_bcast(ibc[1]), .out_valid(ov1), .out_ready(ordy[1][2:0]),
        .out_data(od1), .drop_cnt(dc1), .sel_err(se1));

    int nchecks = 0;
    int nerrors = 0;

    int         nch [2] = '{4, 3};
    bit         zi  [2] = '{1'b1, 1'b0};
    bit         mv  [2][4];
    logic [7:0] md  [2][4];
    int         mdrop [2];
    bit         merr  [2];
    bit         stalled [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic get_rdy(input int id);
        return (id == 0) ? irdy0 : irdy1;
    endfunction

    function automatic logic get_ov(input int id, input int k);
        return (id == 0) ? ov0[k] : ov1[k];
    endfunction

    function automatic logic [7:0] get_od(input int id, input int k);
        return (id == 0) ? od0[k*8 +: 8] : od1[k*8 +: 8];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                mv[d][k] = 1'b0;
                md[d][k] = 8'h00;
            end
            mdrop[d]   = 0;
            merr[d]    = 1'b0;
            stalled[d] = 1'b0;
        end
    endtask

    task automatic check_outs(input int id);
        for (int k = 0; k < nch[id]; k++) begin
            check($sformatf("d%0d_out_valid%0d", id, k), 32'(get_ov(id, k)), 32'(mv[id][k]));
            check($sformatf("d%0d_out_data%0d", id, k), 32'(get_od(id, k)), 32'(md[id][k]));
        end
        check($sformatf("d%0d_drop_cnt", id), 32'(id == 0 ? dc0 : dc1), 32'(mdrop[id]));
        check($sformatf("d%0d_sel_err", id), 32'(id == 0 ? se0 : se1), 32'(merr[id]));
    endtask

    // One clock cycle on instance id: check in_ready, advance model, check registered outputs.
    task automatic step(input int id);
        bit fr [4];
        bit all_free, exp_rdy, acc;
        @(negedge clk);
        all_free = 1'b1;
        for (int k = 0; k < nch[id]; k++) begin
            fr[k]    = !mv[id][k] || ordy[id][k];
            all_free = all_free && fr[k];
        end
        if (ibc[id])
            exp_rdy = all_free;
        else if (int'(isel[id]) >= nch[id])
            exp_rdy = 1'b1;
        else
            exp_rdy = fr[isel[id]];
        check($sformatf("d%0d_in_ready", id), 32'(get_rdy(id)), 32'(exp_rdy));
        acc         = iv[id] && exp_rdy;
        stalled[id] = iv[id] && !exp_rdy;
        for (int k = 0; k < nch[id]; k++) begin
            if (acc && (ibc[id] || int'(isel[id]) == k)) begin
                mv[id][k] = 1'b1;
                md[id][k] = idat[id];
            end else if (mv[id][k] && ordy[id][k]) begin
                mv[id][k] = 1'b0;
                if (zi[id]) md[id][k] = 8'h00;
            end
        end
        if (acc && !ibc[id] && int'(isel[id]) >= nch[id]) begin
            merr[id] = 1'b1;
            if (mdrop[id] < 255) mdrop[id]++;
        end
        @(posedge clk);
        #1;
        check_outs(id);
    endtask

    task automatic send(input int id, input int sel, input logic [7:0] data, input bit bc);
        iv[id]   = 1'b1;
        isel[id] = 2'(sel);
        idat[id] = data;
        ibc[id]  = bc;
        step(id);
    endtask

    task automatic rand_run(input int id, input int n);
        for (int i = 0; i < n; i++) begin
            if (!stalled[id]) begin
                iv[id]   = ($urandom_range(3) != 0);
                ibc[id]  = ($urandom_range(7) == 0);
                isel[id] = 2'($urandom_range(3));
                idat[id] = 8'($urandom);
            end
            ordy[id] = 4'($urandom);
            step(id);
        end
        iv[id]      = 1'b0;
        stalled[id] = 1'b0;
        ordy[id]    = 4'hF;
        step(id);
        ordy[id]    = 4'h0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; ibc[d] = 1'b0; isel[d] = 2'd0; idat[d] = 8'h00; ordy[d] = 4'h0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outs(0);
        check_outs(1);
        @(negedge clk);
        rst = 1'b0;

        // Unicast sweep with every consumer ready.
        ordy[0] = 4'hF;
        for (int k = 0; k < 4; k++) send(0, k, 8'hA0 + 8'(k), 1'b0);
        iv[0] = 1'b0;
        step(0);

        // Back-pressure on channel 2 leaves the other channels flowing.
        ordy[0] = 4'b1011;
        send(0, 2, 8'h55, 1'b0);
        send(0, 2, 8'hAA, 1'b0);
        check("bp_hold55", 32'(get_od(0, 2)), 32'h55);
        send(0, 1, 8'h66, 1'b0);
        ordy[0] = 4'hF;
        send(0, 2, 8'hAA, 1'b0);
        check("bp_refill", 32'(get_od(0, 2)), 32'hAA);
        iv[0] = 1'b0;
        step(0);

        // Broadcast waits for the stalled channel 3.
        ordy[0] = 4'b0111;
        send(0, 3, 8'h11, 1'b0);
        send(0, 0, 8'h3C, 1'b1);
        step(0);
        ordy[0] = 4'hF;
        step(0);
        iv[0] = 1'b0; ibc[0] = 1'b0; ordy[0] = 4'h0;
        step(0);
        for (int k = 0; k < 4; k++) check($sformatf("bcast_ch%0d", k), 32'(get_od(0, k)), 32'h3C);
        ordy[0] = 4'hF;
        step(0);
        ordy[0] = 4'h0;

        rand_run(0, 400);

        // Hold-idle instance keeps data after drain.
        ordy[1] = 4'h0;
        send(1, 0, 8'h77, 1'b0);
        iv[1] = 1'b0;
        ordy[1] = 4'h1;
        step(1);
        check("zi0_hold77", 32'(get_od(1, 0)), 32'h77);
        check("zi0_valid0", 32'(get_ov(1, 0)), 32'h0);
        ordy[1] = 4'h0;

        // Out-of-range select: words swallowed, counter saturates.
        for (int i = 0; i < 300; i++) send(1, 3, 8'(i), 1'b0);
        iv[1] = 1'b0;
        check("oob_drop_sat", 32'(dc1), 32'hFF);
        check("oob_sel_err", 32'(se1), 32'h1);
        check("oob_no_valid", 32'(ov1), 32'h0);

        rand_run(1, 400);

        // Mid-operation asynchronous reset.
        ordy[0] = 4'h0;
        send(0, 0, 8'hC1, 1'b0);
        send(0, 2, 8'hC2, 1'b0);
        iv[0] = 1'b0;
        check("pre_rst_valid", 32'(ov0), 32'h5);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid0", 32'(ov0), 32'h0);
        check("async_rst_data0", od0, 32'h0);
        check("async_rst_drop1", 32'(dc1), 32'h0);
        check("async_rst_err1", 32'(se1), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(0);
        step(1);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
